// File: rtl/fifo_wr_arbiter_pkg.sv
// fifo_arb_pkg
// Shared types and helpers for the FIFO write-side arbiter and its
// round-robin picker.
//   arb_state_e : arbiter FSM states
//   burst_end_e : reason a burst terminated (for assertions/coverage)
//   clog2_min1  : $clog2 clamped to at least 1 bit
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    typedef enum logic [1:0] {
        END_NONE = 2'd0,
        END_LAST = 2'd1,
        END_MAX  = 2'd2,
        END_DROP = 2'd3
    } burst_end_e;

    // Width helper that never returns 0, so single-entry fields stay legal
    function automatic int clog2_min1(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// fifo_wr_arbiter_if
// Bundles the producer handshake and FIFO write port seen by the arbiter.
//   reqValid/reqData/reqLast : producer side, into the arbiter
//   reqReady                 : per-producer accept, out of the arbiter
//   fifoFull                 : registered FIFO full flag, into the arbiter
//   fifoWrEn/fifoDataIn      : FIFO write port, out of the arbiter
//   grantId/busy             : grant status, out of the arbiter
// master = environment (producers + FIFO), slave = arbiter.
interface fifo_wr_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 32
);
    localparam int ID_W = fifo_arb_pkg::clog2_min1(NUM_REQ);

    logic [NUM_REQ-1:0]       reqValid;
    logic [NUM_REQ*WIDTH-1:0] reqData;
    logic [NUM_REQ-1:0]       reqLast;
    logic [NUM_REQ-1:0]       reqReady;
    logic                     fifoFull;
    logic                     fifoWrEn;
    logic [WIDTH-1:0]         fifoDataIn;
    logic [ID_W-1:0]          grantId;
    logic                     busy;

    modport master (
        output reqValid, reqData, reqLast, fifoFull,
        input  reqReady, fifoWrEn, fifoDataIn, grantId, busy
    );

    modport slave (
        input  reqValid, reqData, reqLast, fifoFull,
        output reqReady, fifoWrEn, fifoDataIn, grantId, busy
    );

endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rr_pick
// Combinational round-robin picker: returns the first set bit of req at or
// after ptr, wrapping modulo NUM_REQ.
//   req   : request vector
//   ptr   : starting index (0..NUM_REQ-1)
//   found : at least one request bit is set
//   idx   : selected index (0 when nothing is found)
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = fifo_arb_pkg::clog2_min1(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic               found,
    output logic [ID_W-1:0]    idx
);

    // Scan from the farthest offset down to offset 0 so the candidate
    // closest to ptr is the last one written and therefore wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % NUM_REQ]) begin
                found = 1'b1;
                idx   = ID_W'((int'(ptr) + k) % NUM_REQ);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
// Round-robin write-side arbiter in front of a synchronous FIFO. Grants one
// producer at a time for a burst of at most MAX_BURST words, forwards its
// data to the FIFO write port and back-pressures while the FIFO is full.
//   clk : clock, rising edge
//   rst : asynchronous active-high reset
//   bus : fifo_wr_arbiter_if.slave (producer handshake, FIFO port, status)
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int WIDTH     = 32,
    parameter int MAX_BURST = 4
) (
    input logic               clk,
    input logic               rst,
    fifo_wr_arbiter_if.slave  bus
);

    localparam int ID_W  = clog2_min1(NUM_REQ);
    localparam int CNT_W = clog2_min1(MAX_BURST + 1);

    arb_state_e         state_q, state_d;
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]    grant_id_q, grant_id_d;
    logic [CNT_W-1:0]   burst_cnt_q, burst_cnt_d;
    burst_end_e         end_reason;

    logic               pick_found;
    logic [ID_W-1:0]    pick_idx;
    logic               g_valid;
    logic               g_last;
    logic               xfer;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .req   (bus.reqValid),
        .ptr   (rr_ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign g_valid = bus.reqValid[grant_id_q];
    assign g_last  = bus.reqLast[grant_id_q];
    // fifoFull feeds this path combinationally; the FIFO must register it
    assign xfer    = (state_q == GRANT) && g_valid && !bus.fifoFull;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            grant_id_q  <= '0;
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_id_q  <= grant_id_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    // A dropped request only ends the burst when not full; while full the
    // grant is held regardless of reqValid.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_id_d  = grant_id_q;
        burst_cnt_d = burst_cnt_q;
        end_reason  = END_NONE;

        if (state_q == GRANT) begin
            if (xfer && g_last) begin
                end_reason = END_LAST;
            end else if (xfer && (burst_cnt_q == CNT_W'(MAX_BURST - 1))) begin
                end_reason = END_MAX;
            end else if (!g_valid && !bus.fifoFull) begin
                end_reason = END_DROP;
            end
        end

        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    grant_id_d  = pick_idx;
                    burst_cnt_d = '0;
                    state_d     = GRANT;
                end
            end
            GRANT: begin
                if (xfer) begin
                    burst_cnt_d = burst_cnt_q + CNT_W'(1);
                end
                if (end_reason != END_NONE) begin
                    state_d  = IDLE;
                    // Explicit wrap keeps non-power-of-2 NUM_REQ in range
                    rr_ptr_d = (grant_id_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_id_q + ID_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Data is zeroed whenever no write happens so the FIFO never sees X
    always_comb begin
        bus.busy       = (state_q == GRANT);
        bus.grantId    = grant_id_q;
        bus.fifoWrEn   = xfer;
        bus.reqReady   = '0;
        bus.fifoDataIn = '0;
        if ((state_q == GRANT) && !bus.fifoFull) begin
            bus.reqReady = NUM_REQ'(1) << grant_id_q;
        end
        if (xfer) begin
            bus.fifoDataIn = bus.reqData[int'(grant_id_q) * WIDTH +: WIDTH];
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter
// Self-checking bench for fifo_wr_arbiter: a queue stands in for the FIFO,
// and a transaction-level model (owner/word count/pointer) predicts every
// output each cycle. A second NUM_REQ=3 instance checks pointer wrap.
module tb_fifo_wr_arbiter;

    localparam int N     = 4;
    localparam int W     = 32;
    localparam int MB    = 4;
    localparam int DEPTH = 8;

    logic clk;
    logic rst;

    fifo_wr_arbiter_if #(.NUM_REQ(N), .WIDTH(W)) bus ();
    fifo_wr_arbiter_if #(.NUM_REQ(3), .WIDTH(W)) bus3 ();

    fifo_wr_arbiter #(.NUM_REQ(N), .WIDTH(W), .MAX_BURST(MB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    fifo_wr_arbiter #(.NUM_REQ(3), .WIDTH(W), .MAX_BURST(MB)) dut3 (
        .clk (clk),
        .rst (rst),
        .bus (bus3.slave)
    );

    int pass_cnt;
    int total_cnt;

    // Reference model: who owns the FIFO, how many words they sent, and
    // where the next search starts.
    bit m_busy;
    int m_gnt;
    int m_cnt;
    int m_ptr;

    logic [W-1:0] fifo_q[$];
    logic [W-1:0] sb_q[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
        total_cnt++;
        assert (obs === expv) pass_cnt++;
        else $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    endtask

    task automatic applyStimulus(input logic [N-1:0] valid, input logic [N-1:0] last,
                                 input logic [N*W-1:0] data);
        bus.reqValid = valid;
        bus.reqLast  = last;
        bus.reqData  = data;
    endtask

    function automatic int modelPick(input logic [N-1:0] v, input int from);
        for (int k = 0; k < N; k++) begin
            if (v[(from + k) % N]) return (from + k) % N;
        end
        return -1;
    endfunction

    task automatic modelReset();
        m_busy = 1'b0;
        m_gnt  = 0;
        m_cnt  = 0;
        m_ptr  = 0;
    endtask

    // One clock: entered just after a negedge with inputs applied, returns
    // at the next negedge.
    task automatic runCycle(input bit doRead);
        logic [N-1:0] expReady;
        logic         expWr;
        logic [W-1:0] expData;
        logic         wr;
        logic [W-1:0] wdata;
        logic [W-1:0] got;
        bit           full;
        int           g;
        int           p;

        full         = (fifo_q.size() >= DEPTH);
        bus.fifoFull = full;
        #1;
        g        = m_gnt;
        expWr    = m_busy && bus.reqValid[g] && !full;
        expReady = (m_busy && !full) ? (N'(1) << g) : '0;
        expData  = expWr ? bus.reqData[g*W +: W] : '0;

        checkOutput("busy", W'(bus.busy), W'(m_busy));
        if (m_busy) checkOutput("grantId", W'(bus.grantId), W'(g));
        checkOutput("reqReady", W'(bus.reqReady), W'(expReady));
        checkOutput("fifoWrEn", W'(bus.fifoWrEn), W'(expWr));
        checkOutput("fifoDataIn", bus.fifoDataIn, expData);

        wr    = bus.fifoWrEn;
        wdata = bus.fifoDataIn;
        @(posedge clk);
        if (wr) fifo_q.push_back(wdata);
        if (expWr) sb_q.push_back(expData);
        if (doRead && fifo_q.size() > 0) begin
            got = fifo_q.pop_front();
            if (sb_q.size() == 0) checkOutput("scoreboardDepth", W'(sb_q.size()), W'(1));
            else                  checkOutput("fifoOrder", got, sb_q.pop_front());
        end

        if (!m_busy) begin
            p = modelPick(bus.reqValid, m_ptr);
            if (p >= 0) begin
                m_busy = 1'b1;
                m_gnt  = p;
                m_cnt  = 0;
            end
        end else if (expWr) begin
            m_cnt++;
            if (bus.reqLast[g] || m_cnt == MB) begin
                m_busy = 1'b0;
                m_ptr  = (g + 1) % N;
            end
        end else if (!bus.reqValid[g] && !full) begin
            m_busy = 1'b0;
            m_ptr  = (g + 1) % N;
        end
        @(negedge clk);
    endtask

    initial begin
        logic [N*W-1:0] dv;
        logic [N-1:0]   rv;
        logic [N-1:0]   rl;
        logic           prevBusy;
        int             grants[$];
        int             exp3[5];

        pass_cnt  = 0;
        total_cnt = 0;
        rst       = 1'b1;
        applyStimulus('0, '0, '0);
        bus.fifoFull   = 1'b0;
        bus3.reqValid  = '0;
        bus3.reqLast   = '0;
        bus3.reqData   = '0;
        bus3.fifoFull  = 1'b0;
        modelReset();

        // Reset values
        #2;
        checkOutput("rstBusy", W'(bus.busy), '0);
        checkOutput("rstReqReady", W'(bus.reqReady), '0);
        checkOutput("rstFifoWrEn", W'(bus.fifoWrEn), '0);
        checkOutput("rstFifoDataIn", bus.fifoDataIn, '0);
        checkOutput("rstGrantId", W'(bus.grantId), '0);
        @(negedge clk);
        rst = 1'b0;

        // Single producer: 0x10, 0x11, 0x12 (last)
        dv = '0;
        dv[0 +: W] = 32'h10;
        applyStimulus(4'b0001, 4'b0000, dv);
        runCycle(1'b0);
        runCycle(1'b0);
        dv[0 +: W] = 32'h11;
        applyStimulus(4'b0001, 4'b0000, dv);
        runCycle(1'b0);
        dv[0 +: W] = 32'h12;
        applyStimulus(4'b0001, 4'b0001, dv);
        runCycle(1'b0);
        applyStimulus(4'b0000, 4'b0000, dv);
        runCycle(1'b0);
        checkOutput("singleCount", W'(fifo_q.size()), W'(3));
        if (fifo_q.size() >= 3) begin
            checkOutput("singleWord0", fifo_q[0], 32'h10);
            checkOutput("singleWord1", fifo_q[1], 32'h11);
            checkOutput("singleWord2", fifo_q[2], 32'h12);
        end

        // Pointer moved past producer 0, so producer 1 wins next
        for (int i = 0; i < N; i++) dv[i*W +: W] = 32'h100 + i;
        applyStimulus(4'b0011, 4'b0000, dv);
        runCycle(1'b1);
        #1;
        checkOutput("rrPtrAfterSingle", W'(bus.grantId), W'(1));
        for (int c = 0; c < 6; c++) runCycle(1'b1);

        // All producers valid, no last: full-length bursts in rotation
        for (int c = 0; c < 30; c++) begin
            for (int i = 0; i < N; i++) dv[i*W +: W] = {8'(i), 24'(c)};
            applyStimulus(4'b1111, 4'b0000, dv);
            runCycle(1'b1);
        end

        // Drain, then fill the FIFO from producer 1 without reading
        applyStimulus('0, '0, dv);
        for (int c = 0; c < 12; c++) runCycle(1'b1);
        for (int c = 0; c < 16; c++) begin
            dv[1*W +: W] = 32'h1000 + c;
            applyStimulus(4'b0010, 4'b0000, dv);
            runCycle(1'b0);
        end
        checkOutput("fillDepth", W'(fifo_q.size()), W'(DEPTH));
        runCycle(1'b1);
        runCycle(1'b0);
        runCycle(1'b0);
        checkOutput("oneReadOneWrite", W'(fifo_q.size()), W'(DEPTH));

        // Drop: producer 2 stops after 2 words, producer 3 then gets the grant
        applyStimulus('0, '0, dv);
        for (int c = 0; c < 12; c++) runCycle(1'b1);
        dv[2*W +: W] = 32'h2000;
        applyStimulus(4'b0100, 4'b0000, dv);
        runCycle(1'b1);
        runCycle(1'b1);
        dv[2*W +: W] = 32'h2001;
        applyStimulus(4'b0100, 4'b0000, dv);
        runCycle(1'b1);
        dv[3*W +: W] = 32'h3000;
        applyStimulus(4'b1000, 4'b0000, dv);
        runCycle(1'b1);
        runCycle(1'b1);
        #1;
        checkOutput("dropNextGrant", W'(bus.grantId), W'(3));
        for (int c = 0; c < 4; c++) runCycle(1'b1);

        // Randomized traffic with random back-pressure from slow reads
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                dv[i*W +: W] = $urandom;
                rv[i]        = ($urandom_range(0, 2) != 0);
                rl[i]        = ($urandom_range(0, 3) == 0);
            end
            applyStimulus(rv, rl, dv);
            runCycle(($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0);
        end

        // Async reset in the middle of a producer-2 burst
        applyStimulus('0, '0, dv);
        for (int c = 0; c < 12; c++) runCycle(1'b1);
        applyStimulus(4'b0100, 4'b0000, dv);
        runCycle(1'b1);
        runCycle(1'b1);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("midRstBusy", W'(bus.busy), '0);
        checkOutput("midRstReqReady", W'(bus.reqReady), '0);
        checkOutput("midRstFifoWrEn", W'(bus.fifoWrEn), '0);
        checkOutput("midRstFifoDataIn", bus.fifoDataIn, '0);
        @(negedge clk);
        rst = 1'b0;
        modelReset();
        applyStimulus(4'b1010, 4'b0000, dv);
        runCycle(1'b1);
        #1;
        checkOutput("rstFirstGrant", W'(bus.grantId), W'(1));
        for (int c = 0; c < 6; c++) runCycle(1'b1);

        // NUM_REQ=3 instance: rotation wraps 2 -> 0, never reaches 3
        exp3 = '{0, 1, 2, 0, 1};
        prevBusy = 1'b0;
        bus3.reqData  = {32'hC, 32'hB, 32'hA};
        bus3.reqValid = 3'b111;
        for (int c = 0; c < 26; c++) begin
            #1;
            if (bus3.busy) checkOutput("n3GrantRange", W'(bus3.grantId < 2'd3), W'(1));
            if (bus3.busy && !prevBusy) grants.push_back(int'(bus3.grantId));
            prevBusy = bus3.busy;
            @(negedge clk);
        end
        checkOutput("n3GrantCount", W'(grants.size()), W'(5));
        for (int i = 0; i < 5 && i < grants.size(); i++) begin
            checkOutput("n3GrantOrder", W'(grants[i]), W'(exp3[i]));
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
